// File: rtl/button_debounce.sv
// Debounces one raw push-button pin into a clean level, press/release strobes
// and a wrapping press counter. 2-FF synchronizer followed by a 4-state filter.
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    output logic               btn_level,
    output logic               btn_press,
    output logic               btn_release,
    output logic [COUNT_W-1:0] press_count
);

    localparam int unsigned          CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        UP,
        DOWN_PEND,
        DOWN,
        UP_PEND
    } state_t;

    logic               sync1_q, sync1_d;
    logic               s_q, s_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               accept_press, accept_release;

    always_comb begin
        sync1_d        = button ^ ACTIVE_LOW;
        s_d            = sync1_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept_press   = 1'b0;
        accept_release = 1'b0;

        case (state_q)
            UP: begin
                cnt_d = '0;
                if (s_q) begin
                    if (STABLE_CYCLES == 1) begin
                        accept_press = 1'b1;
                        state_d      = DOWN;
                    end else begin
                        state_d = DOWN_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            DOWN_PEND: begin
                if (!s_q) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept_press = 1'b1;
                    state_d      = DOWN;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                cnt_d = '0;
                if (!s_q) begin
                    if (STABLE_CYCLES == 1) begin
                        accept_release = 1'b1;
                        state_d        = UP;
                    end else begin
                        state_d = UP_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            UP_PEND: begin
                if (s_q) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept_release = 1'b1;
                    state_d        = UP;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase

        // Level and strobes update on the same edge as the state transition.
        level_d   = accept_press ? 1'b1 : (accept_release ? 1'b0 : level_q);
        press_d   = accept_press;
        release_d = accept_release;
        count_d   = accept_press ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            s_q       <= s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: two debouncers (active-low and active-high pins) driven with
// complementary pins must both match the same hand-derived output timeline.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       pin_a;
    logic       pin_b;
    logic       lvl_a, prs_a, rel_a;
    logic       lvl_b, prs_b, rel_b;
    logic [7:0] cnt_a, cnt_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        exp_lvl;
    logic [7:0]  exp_cnt;

    assign pin_b = ~pin_a;

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES(4),
        .ACTIVE_LOW   (1'b1),
        .COUNT_W      (8)
    ) dut_al1 (
        .clk        (clk),
        .rst        (rst),
        .button     (pin_a),
        .btn_level  (lvl_a),
        .btn_press  (prs_a),
        .btn_release(rel_a),
        .press_count(cnt_a)
    );

    button_debounce #(
        .STABLE_CYCLES(4),
        .ACTIVE_LOW   (1'b0),
        .COUNT_W      (8)
    ) dut_al0 (
        .clk        (clk),
        .rst        (rst),
        .button     (pin_b),
        .btn_level  (lvl_b),
        .btn_press  (prs_b),
        .btn_release(rel_b),
        .press_count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input bit p, input bit r);
        check({tag, "/al1"}, {21'b0, lvl_a, prs_a, rel_a, cnt_a}, {21'b0, exp_lvl, p, r, exp_cnt});
        check({tag, "/al0"}, {21'b0, lvl_b, prs_b, rel_b, cnt_b}, {21'b0, exp_lvl, p, r, exp_cnt});
    endtask

    task automatic hold_pin(input string tag, input bit pressed, input int unsigned n);
        pin_a = pressed ? 1'b0 : 1'b1;
        for (int unsigned k = 1; k <= n; k++) begin
            tick();
            check_outs(tag, 1'b0, 1'b0);
        end
    endtask

    // Level change expected exactly at the 6th edge (2 sync + 4 filter).
    task automatic qualify(input string tag, input bit pressed, input int unsigned hold);
        pin_a = pressed ? 1'b0 : 1'b1;
        for (int unsigned k = 1; k <= hold; k++) begin
            tick();
            if (k == 6) begin
                exp_lvl = pressed;
                if (pressed) exp_cnt = exp_cnt + 8'd1;
                check_outs(tag, pressed, !pressed);
            end else begin
                check_outs(tag, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        exp_lvl = 1'b0;
        exp_cnt = 8'd0;
        check_outs(tag, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        pin_a   = 1'b0;
        exp_lvl = 1'b0;
        exp_cnt = 8'd0;

        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_outs("reset", 1'b0, 1'b0);
        end
        rst = 1'b0;
        qualify("t1_held_press", 1'b1, 8);

        qualify("t4_release", 1'b0, 8);

        qualify("t2_press", 1'b1, 10);
        qualify("t2_release", 1'b0, 8);

        hold_pin("t3_bounce", 1'b1, 3);
        hold_pin("t3_bounce", 1'b0, 1);
        hold_pin("t3_bounce", 1'b1, 3);
        hold_pin("t3_bounce", 1'b0, 1);
        qualify("t3_press", 1'b1, 6);
        qualify("t3_release", 1'b0, 8);

        hold_pin("t6_down_pend", 1'b1, 4);
        do_reset("t6_rst_pend");
        qualify("t6_requalify", 1'b1, 7);

        exp_lvl = 1'b1;
        pin_a   = 1'b1;
        for (int unsigned k = 1; k <= 4; k++) begin
            tick();
            check_outs("t6_up_pend", 1'b0, 1'b0);
        end
        do_reset("t6_rst_up_pend");
        hold_pin("t6_idle", 1'b0, 8);

        for (int unsigned i = 1; i <= 256; i++) begin
            qualify("t5_wrap_press", 1'b1, 6);
            if (i == 255) check("t5_cnt255", {24'b0, cnt_a}, 32'd255);
            if (i == 256) begin
                check("t5_cnt0_al1", {24'b0, cnt_a}, 32'd0);
                check("t5_cnt0_al0", {24'b0, cnt_b}, 32'd0);
            end
            qualify("t5_wrap_release", 1'b0, 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
